alu_share_arbiter: RTL and testbench

- Shares the single ALU and its ALUControl decoder among NREQ requesters, for example the fetch PC-increment, branch compare and R-type execute paths.
- Picks one pending requester using round-robin arbitration.
- Latches that requester's function code, ALUOp and operands, then drives them to the ALU/ALUControl pair.
- Captures the result and zero flag, and returns them with a one-cycle done strobe to the granted requester.

---
 rtl/alu_share_arbiter_if.sv | 38 +++
 rtl/alu_share_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Requester/ALU-side bundle of the shared ALU arbiter.
// master: requesters plus the ALU datapath; slave: the arbiter.
interface alu_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 32
);
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] req_func;
    logic [2*NREQ-1:0] req_aluop;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              err;
    logic [W-1:0]      rsp_result;
    logic              rsp_zero;
    logic              busy;
    logic [3:0]        alu_func;
    logic [1:0]        alu_op;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [W-1:0]      alu_result;
    logic              alu_zero;

    modport master (
        output req, req_func, req_aluop, req_a, req_b,
        output alu_result, alu_zero,
        input  grant, done, err, rsp_result, rsp_zero, busy,
        input  alu_func, alu_op, alu_a, alu_b
    );

    modport slave (
        input  req, req_func, req_aluop, req_a, req_b,
        input  alu_result, alu_zero,
        output grant, done, err, rsp_result, rsp_zero, busy,
        output alu_func, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU/ALUControl pair among NREQ requesters.
// Fixed 3-cycle operation: grant, settle, done.
module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32
) (
    input logic clk,
    input logic rst,
    alu_share_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t state, state_nx;

    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   sel;
    logic            found;
    logic            ill;
    logic [3:0]      sel_func;
    logic [1:0]      sel_op;
    logic            sel_ill;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] done_q;
    logic            err_q;
    logic [W-1:0]    result_q;
    logic            zero_q;
    logic            busy_q;
    logic [3:0]      func_q;
    logic [1:0]      op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    int              j;

    // First pending requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req[j]) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
    end

    assign sel_func = bus.req_func[4*int'(sel) +: 4];
    assign sel_op   = bus.req_aluop[2*int'(sel) +: 2];
    assign sel_ill  = (sel_op == 2'b10) &&
                      !(sel_func inside {4'b0000, 4'b0010, 4'b0100,
                                         4'b0101, 4'b1010});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (found) state_nx = EXEC;
            EXEC:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            idx      <= '0;
            ill      <= 1'b0;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            func_q   <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= (state_nx != IDLE);
            if (state == IDLE && found) begin
                grant_q <= NREQ'(1) << sel;
                idx     <= sel;
                ill     <= sel_ill;
                func_q  <= sel_func;
                op_q    <= sel_op;
                a_q     <= bus.req_a[W*int'(sel) +: W];
                b_q     <= bus.req_b[W*int'(sel) +: W];
            end
            // alu_* have been stable since the grant edge; sample now.
            if (state == DONE) begin
                done_q   <= NREQ'(1) << idx;
                err_q    <= ill;
                result_q <= ill ? '0 : bus.alu_result;
                zero_q   <= ill ? 1'b0 : bus.alu_zero;
                rr_ptr   <= (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
            end
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.busy       = busy_q;
    assign bus.alu_func   = func_q;
    assign bus.alu_op     = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_share_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;

    alu_share_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference ALU: unknown R-type codes give a poison value.
    always_comb begin
        bus.alu_result = 32'hDEAD_BEEF;
        if (bus.alu_op == 2'b00) bus.alu_result = bus.alu_a + bus.alu_b;
        else if (bus.alu_op == 2'b01) bus.alu_result = bus.alu_a - bus.alu_b;
        else if (bus.alu_op == 2'b10) begin
            case (bus.alu_func)
                4'b0000: bus.alu_result = bus.alu_a + bus.alu_b;
                4'b0010: bus.alu_result = bus.alu_a - bus.alu_b;
                4'b0100: bus.alu_result = bus.alu_a & bus.alu_b;
                4'b0101: bus.alu_result = bus.alu_a | bus.alu_b;
                4'b1010: bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
                default: bus.alu_result = 32'hDEAD_BEEF;
            endcase
        end
        bus.alu_zero = (bus.alu_result == '0);
    end

    task automatic drive(input int i, input logic [3:0] f, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        bus.req_func[4*i +: 4]  = f;
        bus.req_aluop[2*i +: 2] = op;
        bus.req_a[W*i +: W]     = a;
        bus.req_b[W*i +: W]     = b;
    endtask

    task automatic wait_grant(input int lim, output int n, output logic [NREQ-1:0] g);
        n = 0;
        g = '0;
        while (n < lim && g == '0) begin
            @(negedge clk);
            n++;
            g = bus.grant;
        end
    endtask

    task automatic test_reset;
        bus.req = '0;
        bus.req_func = '0;
        bus.req_aluop = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.grant, bus.done, bus.err, bus.rsp_result, bus.rsp_zero, bus.busy,
             bus.alu_func, bus.alu_op, bus.alu_a, bus.alu_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero grant=%b done=%b busy=%b alu_a=%0d",
                     bus.grant, bus.done, bus.busy, bus.alu_a);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        drive(0, 4'b0000, 2'b10, 32'd5, 32'd7);
        bus.req = 4'b0001;
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got %b want 0001", bus.grant);
        end
        bus.req = '0;
        @(negedge clk);
        checks++;
        if (bus.alu_func !== 4'b0000 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7 ||
            bus.busy !== 1'b1 || bus.grant !== 4'b0000) begin
            errors++;
            $display("FAIL single_exec: func=%b a=%0d b=%0d busy=%b grant=%b want 0000/5/7/1/0000",
                     bus.alu_func, bus.alu_a, bus.alu_b, bus.busy, bus.grant);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 4'b0001 || bus.rsp_result !== 32'd12 ||
            bus.rsp_zero !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%b res=%0d zero=%b err=%b want 0001/12/0/0",
                     bus.done, bus.rsp_result, bus.rsp_zero, bus.err);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 4'b0000 || bus.alu_a !== 32'd5) begin
            errors++;
            $display("FAIL single_after: done=%b alu_a=%0d want 0000/5", bus.done, bus.alu_a);
        end
    endtask

    task automatic test_round_robin;
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] exp;
        int n;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) drive(i, 4'b0010, 2'b10, 32'(20 + 10*i), 32'(i));
        bus.req = 4'b1111;
        exp = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            wait_grant(10, n, g);
            checks++;
            if (g !== exp || n !== (k == 0 ? 1 : 3)) begin
                errors++;
                $display("FAIL rr_grant%0d: grant=%b after %0d cycles want %b after %0d",
                         k, g, n, exp, (k == 0 ? 1 : 3));
            end
            exp = {exp[NREQ-2:0], exp[NREQ-1]};
        end
        bus.req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_pointer_skip;
        logic [NREQ-1:0] g;
        int n;
        drive(1, 4'b0000, 2'b10, 32'd1, 32'd1);
        bus.req = 4'b0010;
        wait_grant(10, n, g);
        bus.req = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (g !== 4'b0010 || bus.done !== 4'b0010 || bus.rsp_result !== 32'd2) begin
            errors++;
            $display("FAIL skip_serve1: grant=%b done=%b res=%0d want 0010/0010/2",
                     g, bus.done, bus.rsp_result);
        end
        bus.req = 4'b1001;
        wait_grant(10, n, g);
        checks++;
        if (g !== 4'b1000 || n !== 1) begin
            errors++;
            $display("FAIL skip_first: grant=%b after %0d want 1000 after 1", g, n);
        end
        bus.req = 4'b0001;
        wait_grant(10, n, g);
        checks++;
        if (g !== 4'b0001 || n !== 3) begin
            errors++;
            $display("FAIL skip_second: grant=%b after %0d want 0001 after 3", g, n);
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_illegal;
        logic [NREQ-1:0] g;
        int n;
        drive(2, 4'b0011, 2'b10, 32'd5, 32'd6);
        bus.req = 4'b0100;
        wait_grant(10, n, g);
        bus.req = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (g !== 4'b0100 || bus.done !== 4'b0100 || bus.err !== 1'b1 ||
            bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL illegal_err: grant=%b done=%b err=%b res=%h zero=%b want 0100/0100/1/0/0",
                     g, bus.done, bus.err, bus.rsp_result, bus.rsp_zero);
        end
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse: err=%b want 0", bus.err);
        end
        drive(2, 4'b0011, 2'b00, 32'd3, 32'd4);
        bus.req = 4'b0100;
        wait_grant(10, n, g);
        bus.req = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.done !== 4'b0100 || bus.err !== 1'b0 || bus.rsp_result !== 32'd7) begin
            errors++;
            $display("FAIL illegal_aluop00: done=%b err=%b res=%0d want 0100/0/7",
                     bus.done, bus.err, bus.rsp_result);
        end
    endtask

    task automatic test_zero;
        logic [NREQ-1:0] g;
        int n;
        drive(0, 4'b0010, 2'b10, 32'd9, 32'd9);
        bus.req = 4'b0001;
        wait_grant(10, n, g);
        bus.req = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.done !== 4'b0001 || bus.rsp_zero !== 1'b1 || bus.rsp_result !== 32'd0) begin
            errors++;
            $display("FAIL zero_flag: done=%b zero=%b res=%0d want 0001/1/0",
                     bus.done, bus.rsp_zero, bus.rsp_result);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [NREQ-1:0] g;
        int n;
        drive(2, 4'b0101, 2'b10, 32'hF0, 32'h0F);
        bus.req = 4'b0100;
        wait_grant(10, n, g);
        checks++;
        if (g !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_grant: grant=%b want 0100", g);
        end
        bus.req = '0;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.grant, bus.done, bus.err, bus.rsp_result, bus.rsp_zero, bus.busy,
             bus.alu_func, bus.alu_op, bus.alu_a, bus.alu_b} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: grant=%b busy=%b alu_a=%h alu_func=%b want all 0",
                     bus.grant, bus.busy, bus.alu_a, bus.alu_func);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.done !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_nodone: done=%b busy=%b want 0000/0", bus.done, bus.busy);
        end
        rst = 1'b0;
        drive(0, 4'b0000, 2'b10, 32'd1, 32'd2);
        drive(3, 4'b0000, 2'b10, 32'd3, 32'd4);
        bus.req = 4'b1001;
        wait_grant(10, n, g);
        checks++;
        if (g !== 4'b0001 || n !== 1) begin
            errors++;
            $display("FAIL midrst_ptr: grant=%b after %0d want 0001 after 1", g, n);
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.done !== 4'b0001 || bus.rsp_result !== 32'd3) begin
            errors++;
            $display("FAIL midrst_done: done=%b res=%0d want 0001/3", bus.done, bus.rsp_result);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_pointer_skip;
        test_illegal;
        test_zero;
        test_reset_mid_op;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
